// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM capture block: FSM state enums,
// frame length derivation and count saturation.
package pwm_pkg;

    typedef enum logic {
        M_IDLE = 1'b0,
        M_RUN  = 1'b1
    } meas_state_t;

    typedef enum logic {
        D_EMPTY = 1'b0,
        D_DRAIN = 1'b1
    } drain_state_t;

    // Widest duty word the saturation helper supports.
    localparam int unsigned MAX_DW = 16;

    function automatic int unsigned frame_len(input int unsigned dw);
        return 32'd1 << dw;
    endfunction

    // Clamp a (dw+1)-bit count to 2^dw-1 so a fully-high frame reads all-ones.
    function automatic logic [MAX_DW:0] sat_count(input logic [MAX_DW:0] cnt,
                                                  input int unsigned dw);
        logic [MAX_DW:0] lim;
        lim = ({{MAX_DW{1'b0}}, 1'b1} << dw) - {{MAX_DW{1'b0}}, 1'b1};
        return (cnt > lim) ? lim : cnt;
    endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// Stream and control bundle between the PWM capture block and its
// environment; the capture block sits on the slave modport.
interface pwm_capture_if #(
    parameter int DWIDTH = 8,
    parameter int STAGE  = 8
);
    localparam int CH_W = (STAGE > 1) ? $clog2(STAGE) : 1;

    logic              hsync;
    logic [STAGE-1:0]  pwm_in;
    logic              clr_err;
    logic [DWIDTH-1:0] out_data;
    logic [CH_W-1:0]   out_ch;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              err_overrun;
    logic              err_sync;

    modport master (
        output hsync, pwm_in, clr_err, out_ready,
        input  out_data, out_ch, out_valid, out_last, err_overrun, err_sync
    );

    modport slave (
        input  hsync, pwm_in, clr_err, out_ready,
        output out_data, out_ch, out_valid, out_last, err_overrun, err_sync
    );
endinterface

// File: rtl/pwm_channel_meter.sv
// Per-channel high-cycle counter; o_count already includes the current
// cycle's sample so the frame's last sample lands in the snapshot.
module pwm_channel_meter
    import pwm_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_en,
    input  logic              i_pwm,
    output logic [DWIDTH-1:0] o_count
);
    logic [DWIDTH:0] r_cnt;
    logic [DWIDTH:0] w_next;

    assign w_next  = r_cnt + {{DWIDTH{1'b0}}, i_pwm};
    assign o_count = DWIDTH'(sat_count((MAX_DW + 1)'(w_next), DWIDTH));

    // Count register: restart on frame cycle 0, accumulate while enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= {{DWIDTH{1'b0}}, i_pwm};
        end else if (i_en) begin
            r_cnt <= w_next;
        end else begin
            r_cnt <= r_cnt;
        end
    end
endmodule

// File: rtl/pwm_capture.sv
// Multi-channel PWM duty decoder: measures one frame of 2^DWIDTH clocks
// per channel, snapshots at frame end and drains words channel 0 first.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int STAGE  = 8
) (
    input logic          clk,
    input logic          rst,
    pwm_capture_if.slave bus
);
    localparam int CH_W = (STAGE > 1) ? $clog2(STAGE) : 1;
    localparam int unsigned FRAME_LEN = frame_len(DWIDTH);
    localparam logic [DWIDTH-1:0] LAST_FCNT = DWIDTH'(FRAME_LEN - 1);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(STAGE - 1);

    meas_state_t       r_mstate;
    logic [DWIDTH-1:0] r_fcnt;
    logic              w_start;
    logic              w_en;
    logic              w_frame_end;
    logic              w_sync_err;

    drain_state_t      r_dstate;
    logic [DWIDTH-1:0] r_snap [STAGE];
    logic [DWIDTH-1:0] w_count [STAGE];
    logic [CH_W-1:0]   r_ch;
    logic [CH_W-1:0]   w_ch_next;
    logic [DWIDTH-1:0] r_data;
    logic              r_valid;
    logic              r_last;
    logic              r_err_ovr;
    logic              r_err_sync;
    logic              w_accept;

    // Meter control: hsync always opens a new frame, even in the last cycle.
    always_comb begin
        w_start     = 1'b0;
        w_en        = 1'b0;
        w_frame_end = 1'b0;
        w_sync_err  = 1'b0;
        case (r_mstate)
            M_IDLE: begin
                w_start = bus.hsync;
            end
            M_RUN: begin
                w_frame_end = (r_fcnt == LAST_FCNT);
                w_start     = bus.hsync;
                w_en        = ~bus.hsync;
                w_sync_err  = bus.hsync & ~w_frame_end;
            end
            default: begin
                w_start = 1'b0;
            end
        endcase
    end

    // Measure FSM and frame cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mstate <= M_IDLE;
            r_fcnt   <= '0;
        end else begin
            case (r_mstate)
                M_IDLE: begin
                    if (bus.hsync) begin
                        r_mstate <= M_RUN;
                        r_fcnt   <= DWIDTH'(1);
                    end else begin
                        r_mstate <= M_IDLE;
                        r_fcnt   <= '0;
                    end
                end
                M_RUN: begin
                    if (bus.hsync) begin
                        r_mstate <= M_RUN;
                        r_fcnt   <= DWIDTH'(1);
                    end else if (w_frame_end) begin
                        r_mstate <= M_IDLE;
                        r_fcnt   <= '0;
                    end else begin
                        r_mstate <= M_RUN;
                        r_fcnt   <= r_fcnt + DWIDTH'(1);
                    end
                end
                default: begin
                    r_mstate <= M_IDLE;
                    r_fcnt   <= '0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < STAGE; g++) begin : g_meter
        pwm_channel_meter #(
            .DWIDTH (DWIDTH)
        ) u_meter (
            .clk     (clk),
            .rst     (rst),
            .i_start (w_start),
            .i_en    (w_en),
            .i_pwm   (bus.pwm_in[g]),
            .o_count (w_count[g])
        );
    end

    assign w_accept  = r_valid & bus.out_ready;
    assign w_ch_next = r_ch + CH_W'(1);

    // Drain FSM: word registers are preloaded so out_data tracks out_ch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dstate <= D_EMPTY;
            r_ch     <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            for (int i = 0; i < STAGE; i++) begin
                r_snap[i] <= '0;
            end
        end else begin
            case (r_dstate)
                D_EMPTY: begin
                    if (w_frame_end) begin
                        for (int i = 0; i < STAGE; i++) begin
                            r_snap[i] <= w_count[i];
                        end
                        r_dstate <= D_DRAIN;
                        r_ch     <= '0;
                        r_data   <= w_count[0];
                        r_valid  <= 1'b1;
                        r_last   <= (LAST_CH == CH_W'(0));
                    end else begin
                        r_dstate <= D_EMPTY;
                    end
                end
                D_DRAIN: begin
                    if (w_accept && r_last) begin
                        r_dstate <= D_EMPTY;
                        r_valid  <= 1'b0;
                        r_last   <= 1'b0;
                    end else if (w_accept) begin
                        r_ch   <= w_ch_next;
                        r_data <= r_snap[w_ch_next];
                        r_last <= (w_ch_next == LAST_CH);
                    end else begin
                        r_dstate <= D_DRAIN;
                    end
                end
                default: begin
                    r_dstate <= D_EMPTY;
                    r_valid  <= 1'b0;
                    r_last   <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flags; a new event wins over a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_ovr  <= 1'b0;
            r_err_sync <= 1'b0;
        end else begin
            if (w_frame_end && (r_dstate == D_DRAIN)) begin
                r_err_ovr <= 1'b1;
            end else if (bus.clr_err) begin
                r_err_ovr <= 1'b0;
            end else begin
                r_err_ovr <= r_err_ovr;
            end
            if (w_sync_err) begin
                r_err_sync <= 1'b1;
            end else if (bus.clr_err) begin
                r_err_sync <= 1'b0;
            end else begin
                r_err_sync <= r_err_sync;
            end
        end
    end

    assign bus.out_data    = r_data;
    assign bus.out_ch      = r_ch;
    assign bus.out_valid   = r_valid;
    assign bus.out_last    = r_last;
    assign bus.err_overrun = r_err_ovr;
    assign bus.err_sync    = r_err_sync;
endmodule
